// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC dot-product accumulator.
// The default accumulator width leaves room for a full vector of maximum-value beats.
package mac_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  localparam int IN_WIDTH_DEF  = 8;
  localparam int VEC_LEN_DEF   = 4;
  localparam int ACC_WIDTH_DEF = IN_WIDTH_DEF + clog2(VEC_LEN_DEF);

endpackage

// File: rtl/mac_dot_accum.sv
// Sums VEC_LEN consecutive MAC results into one dot-product word.
// An early flush emits a partial vector; the result waits on a valid/ready handshake.
module mac_dot_accum
  import mac_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int VEC_LEN   = VEC_LEN_DEF,
  parameter int ACC_WIDTH = IN_WIDTH + clog2(VEC_LEN)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [7:0]           out_len
);

  localparam logic [7:0] LAST_CNT = 8'(VEC_LEN - 1);

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic [7:0]           out_len_q, out_len_d;
  logic                 beat_s;
  logic [ACC_WIDTH-1:0] acc_next_s;

  assign in_ready   = (state_q == ACCUM);
  assign out_valid  = (state_q == HOLD);
  assign out_data   = out_data_q;
  assign out_len    = out_len_q;

  assign beat_s     = in_valid && (state_q == ACCUM);
  // Zero-extend (or truncate) the beat; the sum wraps modulo 2^ACC_WIDTH.
  assign acc_next_s = acc_q + ACC_WIDTH'(in_data);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_len_d  = out_len_q;
    case (state_q)
      ACCUM: begin
        if (beat_s) begin
          if ((cnt_q == LAST_CNT) || flush) begin
            out_data_d = acc_next_s;
            out_len_d  = cnt_q + 8'd1;
            acc_d      = '0;
            cnt_d      = 8'd0;
            state_d    = HOLD;
          end else begin
            acc_d = acc_next_s;
            cnt_d = cnt_q + 8'd1;
          end
        end else if (flush && (cnt_q != 8'd0)) begin
          out_data_d = acc_q;
          out_len_d  = cnt_q;
          acc_d      = '0;
          cnt_d      = 8'd0;
          state_d    = HOLD;
        end else begin
          state_d = ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= 8'd0;
      out_data_q <= '0;
      out_len_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_len_q  <= out_len_d;
    end
  end

endmodule
